// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath defaults, memory-stage FSM states and stage-bundle types.
package cpu_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic valid;
    logic rw;
    logic mem_rd;
    logic mem_wr;
  } stage_ctrl_t;

  // True when the bundle describes a live instruction that must touch data memory.
  function automatic logic needs_dmem(stage_ctrl_t ctrl);
    return ctrl.valid & (ctrl.mem_rd | ctrl.mem_wr);
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: counts consecutive unacknowledged dmem request cycles and flags expiry.
// Only instantiated when DMEM_TIMEOUT_EN is defined.
module dmem_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Restart on every new request window; advance once per unanswered request cycle.
  always_ff @(posedge clk) begin
    if (rst_ || !active || ack) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expired = active & ~ack & (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute/memory pipeline boundary with a blocking data-memory port.
// Build macro DMEM_TIMEOUT_EN bounds the dmem wait and adds a sticky dmem_err flag.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int REG_WORDS = 32,
  parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               valid_s3,
  input  logic               flush_s3,
  input  logic               rw_s3,
  input  logic [ADDR_LEFT:0] waddr_s3,
  input  logic [DATA_W-1:0]  alu_out_s3,
  input  logic               mem_rd_s3,
  input  logic               mem_wr_s3,
  input  logic [DATA_W-1:0]  wdata_s3,
  output logic               stall_s3,
  output logic               rw_s4,
  output logic [ADDR_LEFT:0] waddr_s4,
  output logic [DATA_W-1:0]  alu_out_s4,
  output logic               wb_en_s4,
  output logic [DATA_W-1:0]  wb_data_s4,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               dmem_err
);

  mem_state_t  state;
  mem_state_t  state_next;
  stage_ctrl_t ctrl_s3;
  stage_ctrl_t ctrl_s4;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] load_r;
  logic capture;
  logic ack_edge;

  // A flushed instruction enters stage 4 as a bubble.
  assign ctrl_s3 = '{valid:  valid_s3 & ~flush_s3,
                     rw:     rw_s3,
                     mem_rd: mem_rd_s3,
                     mem_wr: mem_wr_s3};

  assign capture  = (state == ST_IDLE);
  assign ack_edge = (state == ST_REQ) & dmem_ack;

  // A zero-cycle wait window is meaningless; refuse to elaborate it.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("ex_mem_stage: TIMEOUT must be at least 1");
  end

`ifdef DMEM_TIMEOUT_EN
  logic timeout_hit;

  dmem_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_dmem_timer (
    .clk     (clk),
    .rst_    (rst_),
    .active  (state == ST_REQ),
    .ack     (dmem_ack),
    .expired (timeout_hit)
  );

  // Sticky error: set when a request is abandoned, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst_) begin
      dmem_err <= 1'b0;
    end else if (timeout_hit) begin
      dmem_err <= 1'b1;
    end
  end
`else
  assign dmem_err = 1'b0;
`endif

  // Memory-stage state register; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the stall and dmem request outputs, all decoded from state.
  always_comb begin
    state_next = state;
    stall_s3   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (needs_dmem(ctrl_s3)) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_s3   = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = ctrl_s4.mem_wr;
        dmem_addr  = alu_out_s4;
        dmem_wdata = wdata_r;
        if (dmem_ack) begin
          state_next = ST_IDLE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Stage-4 registers load on every unstalled edge; the load register fills on a read ack.
  always_ff @(posedge clk) begin
    if (rst_) begin
      ctrl_s4    <= '0;
      waddr_s4   <= '0;
      alu_out_s4 <= '0;
      wdata_r    <= '0;
      load_r     <= '0;
    end else if (capture) begin
      ctrl_s4    <= ctrl_s3;
      waddr_s4   <= waddr_s3;
      alu_out_s4 <= alu_out_s3;
      wdata_r    <= wdata_s3;
    end else if (ack_edge) begin
      if (ctrl_s4.mem_rd) begin
        load_r <= dmem_rdata;
      end
    end
`ifdef DMEM_TIMEOUT_EN
    else if (timeout_hit) begin
      load_r        <= '0;
      ctrl_s4.valid <= 1'b0;
    end
`endif
  end

  // Load results are not known until the ack, so their destination is never forwarded.
  assign rw_s4      = ctrl_s4.valid & ctrl_s4.rw & ~ctrl_s4.mem_rd;
  assign wb_en_s4   = ctrl_s4.valid & ctrl_s4.rw & (state == ST_IDLE);
  assign wb_data_s4 = ctrl_s4.mem_rd ? load_r : alu_out_s4;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vector table, hand-written reset/timeout sequences and
// randomized instructions checked against an instruction-level model.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_;
  logic        valid_s3;
  logic        flush_s3;
  logic        rw_s3;
  logic [4:0]  waddr_s3;
  logic [31:0] alu_out_s3;
  logic        mem_rd_s3;
  logic        mem_wr_s3;
  logic [31:0] wdata_s3;
  logic        stall_s3;
  logic        rw_s4;
  logic [4:0]  waddr_s4;
  logic [31:0] alu_out_s4;
  logic        wb_en_s4;
  logic [31:0] wb_data_s4;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_err;

  ex_mem_stage dut (
    .clk        (clk),
    .rst_       (rst_),
    .valid_s3   (valid_s3),
    .flush_s3   (flush_s3),
    .rw_s3      (rw_s3),
    .waddr_s3   (waddr_s3),
    .alu_out_s3 (alu_out_s3),
    .mem_rd_s3  (mem_rd_s3),
    .mem_wr_s3  (mem_wr_s3),
    .wdata_s3   (wdata_s3),
    .stall_s3   (stall_s3),
    .rw_s4      (rw_s4),
    .waddr_s4   (waddr_s4),
    .alu_out_s4 (alu_out_s4),
    .wb_en_s4   (wb_en_s4),
    .wb_data_s4 (wb_data_s4),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .dmem_err   (dmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        flush;
    logic        rw;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_rw;
    logic        exp_wb_en;
    logic [31:0] exp_wb_data;
  } vec_t;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic        exp_err      = 1'b0;
  logic [31:0] last_load    = 32'h0;
  vec_t        table_vec[8];

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one instruction into stage 3, answer its dmem request after v.delay cycles,
  // and check every cycle it spends in stage 4.
  task automatic applyStimulus(input vec_t v);
    logic is_mem;
    is_mem     = v.valid & ~v.flush & (v.rd | v.wr);
    valid_s3   = v.valid;
    flush_s3   = v.flush;
    rw_s3      = v.rw;
    waddr_s3   = v.waddr;
    alu_out_s3 = v.alu;
    mem_rd_s3  = v.rd;
    mem_wr_s3  = v.wr;
    wdata_s3   = v.wdata;
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    if (is_mem) begin
      for (int i = 1; i <= v.delay; i++) begin
        valid_s3   = 1'($urandom_range(0, 1));
        flush_s3   = 1'($urandom_range(0, 1));
        rw_s3      = 1'($urandom_range(0, 1));
        waddr_s3   = 5'($urandom);
        alu_out_s3 = $urandom;
        mem_rd_s3  = 1'($urandom_range(0, 1));
        mem_wr_s3  = 1'($urandom_range(0, 1));
        wdata_s3   = $urandom;
        dmem_ack   = (i == v.delay);
        dmem_rdata = (i == v.delay) ? v.rdata : $urandom;
        checkOutput("req_stall", 32'(stall_s3), 32'h1);
        checkOutput("req_dmem_req", 32'(dmem_req), 32'h1);
        checkOutput("req_dmem_addr", dmem_addr, v.alu);
        checkOutput("req_dmem_we", 32'(dmem_we), 32'(v.wr));
        checkOutput("req_dmem_wdata", dmem_wdata, v.wdata);
        checkOutput("req_rw_s4", 32'(rw_s4), 32'(v.exp_rw));
        checkOutput("req_wb_en", 32'(wb_en_s4), 32'h0);
        checkOutput("req_waddr", 32'(waddr_s4), 32'(v.waddr));
        @(posedge clk); #1;
      end
    end
    dmem_ack = 1'b0;
    valid_s3 = 1'b0;
    flush_s3 = 1'b0;
    checkOutput("done_stall", 32'(stall_s3), 32'h0);
    checkOutput("done_dmem_req", 32'(dmem_req), 32'h0);
    checkOutput("done_rw_s4", 32'(rw_s4), 32'(v.exp_rw));
    checkOutput("done_wb_en", 32'(wb_en_s4), 32'(v.exp_wb_en));
    checkOutput("done_wb_data", wb_data_s4, v.exp_wb_data);
    checkOutput("done_waddr", 32'(waddr_s4), 32'(v.waddr));
    checkOutput("done_alu_out", alu_out_s4, v.alu);
    checkOutput("dmem_err", 32'(dmem_err), 32'(exp_err));
  endtask

  // Reference model: the outcome of one instruction from the stage's stated rules.
  function automatic vec_t modelVector(input vec_t v);
    vec_t  r;
    logic  live;
    r    = v;
    live = v.valid & ~v.flush;
    if (live && v.rd) last_load = v.rdata;
    r.exp_rw      = live & v.rw & ~v.rd;
    r.exp_wb_en   = live & v.rw;
    r.exp_wb_data = v.rd ? last_load : v.alu;
    return r;
  endfunction

  initial begin
    rst_       = 1'b1;
    valid_s3   = 1'b0;
    flush_s3   = 1'b0;
    rw_s3      = 1'b0;
    waddr_s3   = 5'h0;
    alu_out_s3 = 32'h0;
    mem_rd_s3  = 1'b0;
    mem_wr_s3  = 1'b0;
    wdata_s3   = 32'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;

    //                  valid  flush  rw     waddr  alu           rd     wr     wdata         dly rdata         rw     wb_en  wb_data
    table_vec[0] = '{1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0010, 1'b0, 1'b0, 32'h0,        0, 32'h0,        1'b1, 1'b1, 32'h0000_0010};
    table_vec[1] = '{1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0040, 1'b1, 1'b0, 32'h0,        3, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF};
    table_vec[2] = '{1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0055, 2, 32'h0,        1'b0, 1'b0, 32'h0000_0080};
    table_vec[3] = '{1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0044, 1'b1, 1'b0, 32'h0,        2, 32'h0000_0BAD, 1'b0, 1'b0, 32'hDEAD_BEEF};
    table_vec[4] = '{1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_0100, 1'b1, 1'b0, 32'h0,        1, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678};
    table_vec[5] = '{1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0104, 1'b1, 1'b0, 32'h0,        2, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D};
    table_vec[6] = '{1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0020, 1'b0, 1'b0, 32'h0,        0, 32'h0,        1'b0, 1'b0, 32'h0000_0020};
    table_vec[7] = '{1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0200, 1'b0, 1'b1, 32'h0000_A5A5, 1, 32'h0,        1'b1, 1'b1, 32'h0000_0200};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", 32'(stall_s3), 32'h0);
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'h0);
    checkOutput("rst_rw_s4", 32'(rw_s4), 32'h0);
    checkOutput("rst_wb_en", 32'(wb_en_s4), 32'h0);
    checkOutput("rst_wb_data", wb_data_s4, 32'h0);
    checkOutput("rst_waddr", 32'(waddr_s4), 32'h0);
    checkOutput("rst_dmem_err", 32'(dmem_err), 32'h0);
    rst_ = 1'b0;

    // Directed table, back to back.
    for (int i = 0; i < 8; i++) begin
      if (table_vec[i].valid && !table_vec[i].flush && table_vec[i].rd) last_load = table_vec[i].rdata;
      applyStimulus(table_vec[i]);
    end

    // Reset in the middle of a request beats a simultaneous ack.
    valid_s3   = 1'b1;
    rw_s3      = 1'b1;
    waddr_s3   = 5'd11;
    alu_out_s3 = 32'h0000_0300;
    mem_rd_s3  = 1'b1;
    mem_wr_s3  = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstreq_pre_stall", 32'(stall_s3), 32'h1);
    checkOutput("rstreq_pre_req", 32'(dmem_req), 32'h1);
    valid_s3   = 1'b0;
    rst_       = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    rst_     = 1'b0;
    dmem_ack = 1'b0;
    last_load = 32'h0;
    checkOutput("rstreq_dmem_req", 32'(dmem_req), 32'h0);
    checkOutput("rstreq_stall", 32'(stall_s3), 32'h0);
    checkOutput("rstreq_wb_en", 32'(wb_en_s4), 32'h0);
    checkOutput("rstreq_rw_s4", 32'(rw_s4), 32'h0);
    checkOutput("rstreq_wb_data", wb_data_s4, 32'h0);
    @(posedge clk); #1;
    checkOutput("rstreq_idle_req", 32'(dmem_req), 32'h0);

    // Randomized instruction stream against the model.
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      int   kind;
      kind    = $urandom_range(0, 2);
      v.valid = ($urandom_range(0, 3) != 0);
      v.flush = ($urandom_range(0, 4) == 0);
      v.rw    = 1'($urandom_range(0, 1));
      v.waddr = 5'($urandom);
      v.alu   = $urandom;
      v.rd    = (kind == 1);
      v.wr    = (kind == 2);
      v.wdata = $urandom;
      v.delay = $urandom_range(1, 5);
      v.rdata = $urandom;
      applyStimulus(modelVector(v));
    end

`ifdef DMEM_TIMEOUT_EN
    // An unanswered request is abandoned after 16 cycles and the error sticks.
    valid_s3   = 1'b1;
    rw_s3      = 1'b1;
    waddr_s3   = 5'd12;
    alu_out_s3 = 32'h0000_0400;
    mem_rd_s3  = 1'b1;
    mem_wr_s3  = 1'b0;
    @(posedge clk); #1;
    valid_s3 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("to_stall", 32'(stall_s3), 32'h1);
      checkOutput("to_err_early", 32'(dmem_err), 32'h0);
      @(posedge clk); #1;
    end
    exp_err   = 1'b1;
    last_load = 32'h0;
    checkOutput("to_stall_after", 32'(stall_s3), 32'h0);
    checkOutput("to_dmem_req", 32'(dmem_req), 32'h0);
    checkOutput("to_dmem_err", 32'(dmem_err), 32'h1);
    checkOutput("to_wb_en", 32'(wb_en_s4), 32'h0);
    checkOutput("to_wb_data", wb_data_s4, 32'h0);
    applyStimulus(modelVector(table_vec[0]));
    applyStimulus(modelVector(table_vec[4]));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter REG_WORDS, default 32, register file depth.
REQ-002 SHALL have parameter ADDR_LEFT, default $clog2(REG_WORDS)-1, register address MSB.
REQ-003 SHALL have parameter DATA_W, default 32, datapath width.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum dmem wait cycles (used only under DMEM_TIMEOUT_EN).
REQ-005 SHALL have ports: clk in 1, clock; rst_ in 1, reset, synchronous and active-high.
REQ-006 SHALL have stage-3 inputs: valid_s3 in 1; flush_s3 in 1; rw_s3 in 1; waddr_s3 in ADDR_LEFT+1; alu_out_s3 in DATA_W; mem_rd_s3 in 1; mem_wr_s3 in 1; wdata_s3 in DATA_W.
REQ-007 SHALL have output stall_s3, 1 bit, which holds stage 3 and upstream.
REQ-008 SHALL have stage-4 outputs: rw_s4 1, forwardable write; waddr_s4 ADDR_LEFT+1; alu_out_s4 DATA_W; wb_en_s4 1; wb_data_s4 DATA_W.
REQ-009 SHALL have dmem ports: dmem_req out 1; dmem_we out 1; dmem_addr out DATA_W; dmem_wdata out DATA_W; dmem_ack in 1; dmem_rdata in DATA_W; dmem_err out 1.

Function
REQ-010 SHALL treat a clk edge with stall_s3=0 as a capture edge: all s3 fields load into s4 registers; valid_s4 <= valid_s3 & ~flush_s3.
REQ-011 SHALL hold all s4 registers and ignore valid_s3 and flush_s3 on edges where stall_s3=1.
REQ-012 SHALL implement FSM IDLE/REQ: IDLE->REQ on a capture edge loading a valid instruction with mem_rd_s3 or mem_wr_s3; REQ->IDLE on the edge where dmem_ack=1.
REQ-013 SHALL drive stall_s3 = (state==REQ) combinationally.
REQ-014 SHALL in REQ drive dmem_req=1, dmem_we=captured mem_wr, dmem_addr=alu_out_s4, dmem_wdata=captured wdata, all stable until the ack edge; SHALL drive dmem_req=0 in IDLE.
REQ-015 SHALL ignore dmem_ack while in IDLE.
REQ-016 SHALL register dmem_rdata into a load register on the ack edge of a read.
REQ-017 SHALL drive rw_s4 = valid_s4 & rw & ~mem_rd, so that load addresses are never forwarded.
REQ-018 SHALL drive wb_en_s4 = valid_s4 & rw & (state==IDLE), suppressing it on the waddr==0 case only by downstream writeback logic.
REQ-019 SHALL drive wb_data_s4 = load register for reads, alu_out_s4 otherwise.
REQ-020 SHALL give latencies: a non-memory instruction occupies s4 exactly 1 cycle; a memory instruction occupies s4 for 1 + N + 1 cycles when ack arrives N+1 cycles after capture (N>=0).
REQ-021 SHALL treat flush_s3 only as a bubble at capture and SHALL never abort an in-flight REQ.
REQ-022 SHALL on back-to-back memory instructions enter REQ again on the capture edge that follows the IDLE cycle.

Reset
REQ-023 SHALL on rst_=1 at an edge force state=IDLE, valid_s4=0, all s4 data/address registers=0, load register=0, and dmem_err=0; outputs are then stall_s3=0, dmem_req=0, rw_s4=0, wb_en_s4=0.
REQ-024 SHALL give rst_ asserted mid-REQ priority over dmem_ack, dropping the access without retry.

Configuration
REQ-025 SHALL, with DMEM_TIMEOUT_EN defined, count REQ cycles; on reaching TIMEOUT cycles without ack, go to IDLE, clear the load register, clear valid_s4, and set dmem_err sticky until reset; an ack in the same cycle wins over the timeout.
REQ-026 SHALL, without DMEM_TIMEOUT_EN, wait in REQ indefinitely with dmem_err tied to 0 and no counter logic present.

Structure
REQ-027 SHALL place the DATA_W default, the FSM state enum, and the s3/s4 stage-bundle typedef in shared package cpu_pkg.
REQ-028 SHALL put the timeout counter in sub-module dmem_timer, instantiated only under DMEM_TIMEOUT_EN; all other logic stays flat.

Verification
REQ-029 SHALL cover ALU op: valid_s3=1, rw=1, waddr=5, alu_out=0x10 -> next cycle rw_s4=1, waddr_s4=5, wb_data_s4=0x10, stall_s3=0.
REQ-030 SHALL cover load: mem_rd=1, alu_out=0x40, ack 3 cycles after capture with rdata=0xDEADBEEF -> dmem_addr=0x40, stall_s3 high 3 cycles, rw_s4=0 throughout, wb_data_s4=0xDEADBEEF with wb_en_s4=1 for 1 cycle.
REQ-031 SHALL cover store: mem_wr=1, wdata=0x55 -> dmem_we=1, dmem_wdata=0x55, wb_en_s4=0.
REQ-032 SHALL cover flush: flush_s3=1 with a valid load -> no dmem_req, valid_s4=0.
REQ-033 SHALL cover reset during REQ -> next cycle dmem_req=0, stall_s3=0, valid_s4=0.
REQ-034 SHALL cover timeout (macro on, TIMEOUT=16): no ack -> after 16 REQ cycles state IDLE, dmem_err=1 and stays 1.
